// File: rtl/traffic_mode_ctrl.sv
// Traffic intersection mode controller: NORMAL / PARADE / NIGHT / EMERG with a
// saturating dwell counter that gates every non-emergency mode change.
module traffic_mode_ctrl #(
  parameter int MIN_DWELL = 4,
  parameter int CNT_W     = 3
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_p,
  input  logic             i_r,
  input  logic             i_n,
  input  logic             i_e,
  output logic [1:0]       o_mode,
  output logic             o_m,
  output logic             o_flash,
  output logic             o_allred,
  output logic             o_chg,
  output logic [CNT_W-1:0] o_dwell
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    PARADE = 2'd1,
    NIGHT  = 2'd2,
    EMERG  = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MIN_DWELL);

  mode_t            mode_q;
  mode_t            mode_nxt;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] dwell_nxt;
  logic             done;

  assign done = (dwell_q == DWELL_MAX);

  // Emergency preempts everything; other changes wait for the dwell to expire.
  always_comb begin
    mode_nxt = mode_q;
    unique case (mode_q)
      NORMAL: begin
        if (i_e)                mode_nxt = EMERG;
        else if (done && i_p)   mode_nxt = PARADE;
        else if (done && i_n)   mode_nxt = NIGHT;
      end
      PARADE: begin
        if (i_e)                mode_nxt = EMERG;
        else if (done && i_r)   mode_nxt = NORMAL;
      end
      NIGHT: begin
        if (i_e)                mode_nxt = EMERG;
        else if (done && i_r)   mode_nxt = NORMAL;
        else if (done && i_p)   mode_nxt = PARADE;
      end
      EMERG: begin
        if (!i_e && done)       mode_nxt = NORMAL;
      end
      default:                  mode_nxt = NORMAL;
    endcase
  end

  // Counter restarts on entry and is pinned at zero while an emergency is active.
  always_comb begin
    dwell_nxt = dwell_q;
    if (mode_nxt != mode_q)             dwell_nxt = '0;
    else if (mode_q == EMERG && i_e)    dwell_nxt = '0;
    else if (!done)                     dwell_nxt = dwell_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      mode_q   <= NORMAL;
      dwell_q  <= '0;
      o_m      <= 1'b0;
      o_flash  <= 1'b0;
      o_allred <= 1'b0;
      o_chg    <= 1'b0;
    end else begin
      mode_q   <= mode_nxt;
      dwell_q  <= dwell_nxt;
      o_m      <= (mode_nxt == PARADE);
      o_flash  <= (mode_nxt == NIGHT);
      o_allred <= (mode_nxt == EMERG);
      o_chg    <= (mode_nxt != mode_q);
    end
  end

  assign o_mode  = mode_q;
  assign o_dwell = dwell_q;

endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// Self-checking bench for traffic_mode_ctrl: directed scenarios followed by
// random requests, all checked against a request-priority reference model.
module tb_traffic_mode_ctrl;

  localparam int MIN_DWELL = 4;
  localparam int CNT_W     = 3;

  logic             i_clk = 1'b0;
  logic             i_rstn;
  logic             i_p;
  logic             i_r;
  logic             i_n;
  logic             i_e;
  logic [1:0]       o_mode;
  logic             o_m;
  logic             o_flash;
  logic             o_allred;
  logic             o_chg;
  logic [CNT_W-1:0] o_dwell;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: mode number, cycles since entry (capped), change flag.
  int m_mode = 0;
  int m_age  = 0;
  int m_chg  = 0;

  // Bit t of allowed[m] is set when mode m may move to mode t on a request.
  bit [3:0] allowed [4] = '{4'b0110, 4'b0001, 4'b0011, 4'b0000};

  traffic_mode_ctrl #(.MIN_DWELL(MIN_DWELL), .CNT_W(CNT_W)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_p     (i_p),
    .i_r     (i_r),
    .i_n     (i_n),
    .i_e     (i_e),
    .o_mode  (o_mode),
    .o_m     (o_m),
    .o_flash (o_flash),
    .o_allred(o_allred),
    .o_chg   (o_chg),
    .o_dwell (o_dwell)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".mode"},   32'(o_mode),   32'(m_mode));
    checkVal({tag, ".m"},      32'(o_m),      32'(m_mode == 1));
    checkVal({tag, ".flash"},  32'(o_flash),  32'(m_mode == 2));
    checkVal({tag, ".allred"}, 32'(o_allred), 32'(m_mode == 3));
    checkVal({tag, ".chg"},    32'(o_chg),    32'(m_chg));
    checkVal({tag, ".dwell"},  32'(o_dwell),  32'(m_age));
  endtask

  // Requests are tried in priority order r > p > n; emergency is handled first.
  task automatic modelStep(input logic rstn, input logic p, input logic r,
                           input logic n, input logic e);
    int  nxt;
    int  tgt  [3];
    bit  reqs [3];
    bit  done;
    tgt  = '{0, 1, 2};
    reqs = '{r, p, n};
    done = (m_age == MIN_DWELL);
    if (!rstn) begin
      m_mode = 0;
      m_age  = 0;
      m_chg  = 0;
    end else begin
      nxt = m_mode;
      if (e) nxt = 3;
      else if (m_mode == 3) begin
        if (done) nxt = 0;
      end else if (done) begin
        for (int k = 0; k < 3; k++) begin
          if (reqs[k] && allowed[m_mode][tgt[k]]) begin
            nxt = tgt[k];
            break;
          end
        end
      end
      m_chg = (nxt != m_mode) ? 1 : 0;
      if (m_chg == 1 || (nxt == 3 && e)) m_age = 0;
      else if (m_age < MIN_DWELL) m_age++;
      m_mode = nxt;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rstn, input logic p,
                               input logic r, input logic n, input logic e);
    i_rstn = rstn;
    i_p    = p;
    i_r    = r;
    i_n    = n;
    i_e    = e;
    modelStep(rstn, p, r, n, e);
    @(posedge i_clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rstn = 1'b0; i_p = 1'b0; i_r = 1'b0; i_n = 1'b0; i_e = 1'b0;
    #2;

    applyStimulus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("reset", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkVal("reset_mode", 32'(o_mode), 32'd0);

    // Held parade request: four dwell edges in NORMAL, change on the fifth.
    for (int i = 0; i < 4; i++) applyStimulus("parade_hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("parade_wait_mode", 32'(o_mode), 32'd0);
    checkVal("parade_wait_dwell", 32'(o_dwell), 32'd4);
    applyStimulus("parade_enter", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("parade_enter_mode", 32'(o_mode), 32'd1);
    checkVal("parade_enter_chg", 32'(o_chg), 32'd1);
    applyStimulus("parade_stay", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("parade_chg_once", 32'(o_chg), 32'd0);

    // Early return pulse is dropped; a held one takes effect after done.
    applyStimulus("ret_pulse", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("ret_gap",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("ret_pulse_ignored", 32'(o_mode), 32'd1);
    applyStimulus("ret_hold",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("ret_hold",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("ret_to_normal", 32'(o_mode), 32'd0);

    // Emergency from NORMAL at dwell 1, then release and recover.
    idle("emerg_pre", 1);
    for (int i = 0; i < 3; i++) applyStimulus("emerg_on", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("emerg_allred", 32'(o_allred), 32'd1);
    checkVal("emerg_dwell0", 32'(o_dwell), 32'd0);
    idle("emerg_off", 4);
    checkVal("emerg_still", 32'(o_mode), 32'd3);
    idle("emerg_exit", 1);
    checkVal("emerg_exit_mode", 32'(o_mode), 32'd0);

    // Priority cases.
    idle("prio_wait", 4);
    applyStimulus("prio_pn", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkVal("prio_pn_mode", 32'(o_mode), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus("prio_back", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("prio_wait", 4);
    applyStimulus("night_enter", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("night_mode", 32'(o_mode), 32'd2);
    idle("night_wait", 4);
    applyStimulus("prio_rp", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("prio_rp_mode", 32'(o_mode), 32'd0);
    idle("prio_wait", 4);
    applyStimulus("night_enter2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("night_wait2", 4);
    applyStimulus("prio_er", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkVal("prio_er_mode", 32'(o_mode), 32'd3);

    // Reset in the middle of an emergency, emergency still requested.
    applyStimulus("emerg_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("emerg_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("emerg_rst_mode", 32'(o_mode), 32'd0);
    checkVal("emerg_rst_allred", 32'(o_allred), 32'd0);
    applyStimulus("emerg_rerun", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("emerg_rerun_mode", 32'(o_mode), 32'd3);

    // Random requests; emergencies and resets kept rare so dwells complete.
    for (int i = 0; i < 600; i++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 59) != 0),
                    1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
